decode_stage_pipelined: RTL and testbench

- Parametrised, handshaked instruction-decode stage for one core.
- Sits between the fetcher and the register-read/execute logic.
- Replaces the core_state-gated decoder with valid/ready flow control, a 2-entry skid buffer, illegal-opcode detection, a flush input and a decoded-instruction counter.
- One decoded bundle per accepted instruction. Latency is 1 cycle.

---
 rtl/decode_stage_pipelined.sv | 165 ++++++++++++++++
 tb/tb_decode_stage_pipelined.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_pipelined.sv
// Handshaked instruction-decode stage: combinational decode into a main output
// register backed by one skid register, with flush and a consumed-bundle counter.
module decode_stage_pipelined #(
  parameter  int REG_ADDR_WIDTH = 4,
  parameter  int PC_WIDTH       = 8,
  parameter  int COUNT_WIDTH    = 16,
  localparam int R              = REG_ADDR_WIDTH,
  localparam int W              = 4 + 3 * REG_ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_instruction,
  input  logic [PC_WIDTH-1:0]    in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PC_WIDTH-1:0]    out_pc,
  output logic [R-1:0]           decoded_rd_address,
  output logic [R-1:0]           decoded_rs_address,
  output logic [R-1:0]           decoded_rt_address,
  output logic [2:0]             decoded_nzp,
  output logic [2*R-1:0]         decoded_immediate,
  output logic                   decoded_reg_write_enable,
  output logic                   decoded_mem_read_enable,
  output logic                   decoded_mem_write_enable,
  output logic                   decoded_nzp_write_enable,
  output logic [1:0]             decoded_reg_input_mux,
  output logic [1:0]             decoded_alu_arithmetic_mux,
  output logic                   decoded_alu_output_mux,
  output logic                   decoded_pc_mux,
  output logic                   decoded_ret,
  output logic                   decoded_illegal,
  output logic [COUNT_WIDTH-1:0] decoded_count
);

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [R-1:0]        rd;
    logic [R-1:0]        rs;
    logic [R-1:0]        rt;
    logic [2:0]          nzp;
    logic [2*R-1:0]      imm;
    logic                reg_we;
    logic                mem_rd;
    logic                mem_we;
    logic                nzp_we;
    logic [1:0]          rim;
    logic [1:0]          arith;
    logic                alu_out;
    logic                pc_mux;
    logic                ret;
    logic                illegal;
  } t_bundle;

  function automatic t_bundle decode(input logic [W-1:0] instr, input logic [PC_WIDTH-1:0] pc);
    t_bundle b;
    b       = '0;
    b.pc    = pc;
    b.rd    = instr[W-5 -: R];
    b.rs    = instr[2*R-1 -: R];
    b.rt    = instr[R-1:0];
    b.nzp   = instr[W-5 -: 3];
    b.imm   = instr[2*R-1:0];
    case (instr[W-1 -: 4])
      4'b0000: ;
      4'b0001: b.pc_mux = 1'b1;
      4'b0010: begin b.alu_out = 1'b1; b.nzp_we = 1'b1; end
      4'b0011: b.reg_we = 1'b1;
      4'b0100: begin b.reg_we = 1'b1; b.arith = 2'b01; end
      4'b0101: begin b.reg_we = 1'b1; b.arith = 2'b10; end
      4'b0110: begin b.reg_we = 1'b1; b.arith = 2'b11; end
      4'b0111: begin b.reg_we = 1'b1; b.mem_rd = 1'b1; b.rim = 2'b01; end
      4'b1000: b.mem_we = 1'b1;
      4'b1001: begin b.reg_we = 1'b1; b.rim = 2'b10; end
      4'b1111: b.ret = 1'b1;
      default: b.illegal = 1'b1;
    endcase
    return b;
  endfunction

  t_bundle                r_main_p1, r_skid_p1, w_dec_p0;
  t_bundle                w_main_nxt, w_skid_nxt;
  logic                   r_main_vld_p1, r_skid_vld_p1, r_in_ready;
  logic                   w_main_vld_nxt, w_skid_vld_nxt;
  logic                   w_acc, w_drain, w_main_free;
  logic [COUNT_WIDTH-1:0] r_count;

  // p0: raw instruction -> decoded bundle
  assign w_dec_p0    = decode(in_instruction, in_pc);
  assign w_acc       = in_valid && r_in_ready && !flush;
  assign w_drain     = r_main_vld_p1 && out_ready;
  assign w_main_free = !r_main_vld_p1 || w_drain;

  // An emptied main register loads zeros so no stale strobes are presented.
  always_comb begin
    w_main_nxt     = r_main_p1;
    w_main_vld_nxt = r_main_vld_p1;
    w_skid_nxt     = r_skid_p1;
    w_skid_vld_nxt = r_skid_vld_p1;
    if (flush) begin
      w_main_nxt     = '0;
      w_main_vld_nxt = 1'b0;
      w_skid_nxt     = '0;
      w_skid_vld_nxt = 1'b0;
    end else if (w_main_free) begin
      if (r_skid_vld_p1) begin
        w_main_nxt     = r_skid_p1;
        w_main_vld_nxt = 1'b1;
        w_skid_nxt     = '0;
        w_skid_vld_nxt = 1'b0;
      end else if (w_acc) begin
        w_main_nxt     = w_dec_p0;
        w_main_vld_nxt = 1'b1;
      end else begin
        w_main_nxt     = '0;
        w_main_vld_nxt = 1'b0;
      end
    end else if (w_acc) begin
      w_skid_nxt     = w_dec_p0;
      w_skid_vld_nxt = 1'b1;
    end
  end

  // p1: main/skid registers, registered ready and consumed counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_main_p1     <= '0;
      r_skid_p1     <= '0;
      r_main_vld_p1 <= 1'b0;
      r_skid_vld_p1 <= 1'b0;
      r_in_ready    <= 1'b0;
      r_count       <= '0;
    end else begin
      r_main_p1     <= w_main_nxt;
      r_skid_p1     <= w_skid_nxt;
      r_main_vld_p1 <= w_main_vld_nxt;
      r_skid_vld_p1 <= w_skid_vld_nxt;
      r_in_ready    <= !w_skid_vld_nxt;
      if (w_drain) r_count <= r_count + COUNT_WIDTH'(1);
    end
  end

  assign in_ready                   = r_in_ready;
  assign out_valid                  = r_main_vld_p1;
  assign out_pc                     = r_main_p1.pc;
  assign decoded_rd_address         = r_main_p1.rd;
  assign decoded_rs_address         = r_main_p1.rs;
  assign decoded_rt_address         = r_main_p1.rt;
  assign decoded_nzp                = r_main_p1.nzp;
  assign decoded_immediate          = r_main_p1.imm;
  assign decoded_reg_write_enable   = r_main_p1.reg_we;
  assign decoded_mem_read_enable    = r_main_p1.mem_rd;
  assign decoded_mem_write_enable   = r_main_p1.mem_we;
  assign decoded_nzp_write_enable   = r_main_p1.nzp_we;
  assign decoded_reg_input_mux      = r_main_p1.rim;
  assign decoded_alu_arithmetic_mux = r_main_p1.arith;
  assign decoded_alu_output_mux     = r_main_p1.alu_out;
  assign decoded_pc_mux             = r_main_p1.pc_mux;
  assign decoded_ret                = r_main_p1.ret;
  assign decoded_illegal            = r_main_p1.illegal;
  assign decoded_count              = r_count;

endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Directed bench for decode_stage_pipelined: reset, opcode sweep, backpressure,
// flush, asynchronous reset mid-stream and a REG_ADDR_WIDTH = 5 instance.
module tb_decode_stage_pipelined;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_instruction;
  logic [7:0]  in_pc, out_pc, imm;
  logic [3:0]  rd, rs, rt;
  logic [2:0]  nzp;
  logic        reg_we, mem_rd, mem_we, nzp_we, alu_out, pc_mux, ret, illegal;
  logic [1:0]  rim, arith;
  logic [15:0] count;
  logic [11:0] ctl;

  logic        in_valid5, in_ready5, out_valid5;
  logic [18:0] in_instruction5;
  logic [7:0]  in_pc5, out_pc5;
  logic [9:0]  imm5;
  logic [4:0]  rd5, rs5, rt5;
  logic [2:0]  nzp5;
  logic        reg_we5, mem_rd5, mem_we5, nzp_we5, alu_out5, pc_mux5, ret5, illegal5;
  logic [1:0]  rim5, arith5;
  logic [15:0] count5;
  logic [11:0] ctl5;

  int n_chk  = 0;
  int n_fail = 0;

  logic [11:0] exp_ctl [16] = '{12'h000, 12'h004, 12'h108, 12'h800, 12'h810, 12'h820,
                                12'h830, 12'hC40, 12'h200, 12'h880, 12'h001, 12'h001,
                                12'h001, 12'h001, 12'h001, 12'h002};

  always #5 clk = ~clk;

  assign ctl  = {reg_we, mem_rd, mem_we, nzp_we, rim, arith, alu_out, pc_mux, ret, illegal};
  assign ctl5 = {reg_we5, mem_rd5, mem_we5, nzp_we5, rim5, arith5, alu_out5, pc_mux5, ret5, illegal5};

  decode_stage_pipelined #(.REG_ADDR_WIDTH(4), .PC_WIDTH(8), .COUNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instruction(in_instruction), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .decoded_rd_address(rd), .decoded_rs_address(rs), .decoded_rt_address(rt),
    .decoded_nzp(nzp), .decoded_immediate(imm), .decoded_reg_write_enable(reg_we),
    .decoded_mem_read_enable(mem_rd), .decoded_mem_write_enable(mem_we),
    .decoded_nzp_write_enable(nzp_we), .decoded_reg_input_mux(rim),
    .decoded_alu_arithmetic_mux(arith), .decoded_alu_output_mux(alu_out),
    .decoded_pc_mux(pc_mux), .decoded_ret(ret), .decoded_illegal(illegal), .decoded_count(count)
  );

  decode_stage_pipelined #(.REG_ADDR_WIDTH(5), .PC_WIDTH(8), .COUNT_WIDTH(16)) dut5 (
    .clk(clk), .reset(reset), .flush(1'b0), .in_valid(in_valid5), .in_ready(in_ready5),
    .in_instruction(in_instruction5), .in_pc(in_pc5), .out_valid(out_valid5), .out_ready(1'b1),
    .out_pc(out_pc5), .decoded_rd_address(rd5), .decoded_rs_address(rs5), .decoded_rt_address(rt5),
    .decoded_nzp(nzp5), .decoded_immediate(imm5), .decoded_reg_write_enable(reg_we5),
    .decoded_mem_read_enable(mem_rd5), .decoded_mem_write_enable(mem_we5),
    .decoded_nzp_write_enable(nzp_we5), .decoded_reg_input_mux(rim5),
    .decoded_alu_arithmetic_mux(arith5), .decoded_alu_output_mux(alu_out5),
    .decoded_pc_mux(pc_mux5), .decoded_ret(ret5), .decoded_illegal(illegal5), .decoded_count(count5)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] instr, input logic [7:0] pc);
    in_valid       = 1'b1;
    in_instruction = instr;
    in_pc          = pc;
  endtask

  task automatic reset_dut();
    reset    = 1'b0;
    in_valid = 1'b0;
    flush    = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
    in_instruction = 16'h0; in_pc = 8'h0;
    in_valid5 = 1'b0; in_instruction5 = 19'h0; in_pc5 = 8'h0;

    // reset held low with random traffic presented
    repeat (2) begin
      in_instruction = 16'($urandom);
      in_pc          = 8'($urandom);
      tick();
    end
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_ctl", ctl, 0);
    chk("rst_fields", {rd, rs, rt, nzp, imm}, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_count", count, 0);
    reset = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("rel_in_ready", in_ready, 1);
    chk("rel_out_valid", out_valid, 0);

    // opcode sweep at full rate
    out_ready = 1'b1;
    for (int op = 0; op < 16; op++) begin
      drive({op[3:0], 12'hA5C}, 8'(8'h10 + op));
      tick();
      chk($sformatf("sw%0d_vld", op), out_valid, 1);
      chk($sformatf("sw%0d_ctl", op), ctl, exp_ctl[op]);
      chk($sformatf("sw%0d_regs", op), {rd, rs, rt}, 12'hA5C);
      chk($sformatf("sw%0d_imm", op), imm, 8'h5C);
      chk($sformatf("sw%0d_nzp", op), nzp, 3'b101);
      chk($sformatf("sw%0d_pc", op), out_pc, 8'(8'h10 + op));
      chk($sformatf("sw%0d_rdy", op), in_ready, 1);
    end
    in_valid = 1'b0;
    tick();
    chk("sw_drained", out_valid, 0);
    chk("sw_count", count, 16);

    // backpressure: ADD in main, SUB in skid, LDR refused until space frees
    reset_dut();
    chk("bp_count0", count, 0);
    out_ready = 1'b0;
    drive(16'h3123, 8'h30);
    tick();
    chk("bp_add_vld", out_valid, 1);
    chk("bp_add_ctl", ctl, 12'h800);
    drive(16'h4456, 8'h31);
    tick();
    chk("bp_skid_rdy", in_ready, 0);
    chk("bp_hold_pc", out_pc, 8'h30);
    drive(16'h7789, 8'h32);
    tick();
    chk("bp_full_rdy", in_ready, 0);
    chk("bp_stable_pc", out_pc, 8'h30);
    chk("bp_stable_ctl", ctl, 12'h800);
    chk("bp_stable_rd", rd, 4'h1);
    out_ready = 1'b1;
    tick();
    chk("bp_sub_pc", out_pc, 8'h31);
    chk("bp_sub_ctl", ctl, 12'h810);
    chk("bp_sub_rd", rd, 4'h4);
    chk("bp_rdy_back", in_ready, 1);
    chk("bp_count1", count, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_ldr_pc", out_pc, 8'h32);
    chk("bp_ldr_ctl", ctl, 12'hC40);
    chk("bp_ldr_rd", rd, 4'h7);
    tick();
    chk("bp_empty", out_valid, 0);
    chk("bp_count3", count, 3);

    // flush with main and skid full, instruction presented in the same cycle
    out_ready = 1'b0;
    drive(16'h3111, 8'h40);
    tick();
    drive(16'h4222, 8'h41);
    tick();
    chk("fl_pre_rdy", in_ready, 0);
    drive(16'h9333, 8'h42);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    chk("fl_ctl", ctl, 0);
    chk("fl_fields", {out_pc, rd, rs, rt, imm}, 0);
    chk("fl_count", count, 3);
    out_ready = 1'b1;
    tick();
    chk("fl_dropped", out_valid, 0);
    chk("fl_count_kept", count, 3);

    // flush beats an accept while main is stalled and skid empty
    out_ready = 1'b0;
    drive(16'h3444, 8'h50);
    tick();
    drive(16'h4555, 8'h51);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl2_out_valid", out_valid, 0);
    chk("fl2_in_ready", in_ready, 1);
    out_ready = 1'b1;
    tick();
    chk("fl2_dropped", out_valid, 0);

    // asynchronous reset during a burst
    for (int i = 0; i < 3; i++) begin
      drive({4'h3, 4'(i), 8'h00}, 8'(8'h60 + i));
      tick();
    end
    chk("ar_vld", out_valid, 1);
    chk("ar_pc", out_pc, 8'h62);
    chk("ar_count_pre", count, 5);
    drive(16'h3300, 8'h63);
    #3;
    reset = 1'b0;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_ctl", ctl, 0);
    chk("ar_pc0", out_pc, 0);
    chk("ar_in_ready", in_ready, 0);
    chk("ar_count", count, 0);
    drive(16'h3400, 8'h64);
    tick();
    chk("ar_held", out_valid, 0);
    reset = 1'b1; in_valid = 1'b0;
    tick();
    chk("ar_rel_rdy", in_ready, 1);
    chk("ar_rel_vld", out_valid, 0);
    drive(16'h9BE7, 8'h77);
    tick();
    in_valid = 1'b0;
    chk("ar_new_vld", out_valid, 1);
    chk("ar_new_ctl", ctl, 12'h880);
    chk("ar_new_imm", imm, 8'hE7);
    chk("ar_new_rd", rd, 4'hB);
    chk("ar_new_pc", out_pc, 8'h77);
    chk("ar_new_count", count, 0);
    tick();
    chk("ar_count1", count, 1);

    // wider register addresses: CONST with a 10-bit immediate
    in_valid5       = 1'b1;
    in_instruction5 = 19'b1001_10110_1011110011;
    in_pc5          = 8'h5A;
    tick();
    in_valid5 = 1'b0;
    chk("p5_vld", out_valid5, 1);
    chk("p5_imm", imm5, 10'h2F3);
    chk("p5_rim", rim5, 2'b10);
    chk("p5_ctl", ctl5, 12'h880);
    chk("p5_rd", rd5, 5'h16);
    chk("p5_rs_rt", {rs5, rt5}, {5'h17, 5'h13});
    chk("p5_nzp", nzp5, 3'b101);
    chk("p5_pc", out_pc5, 8'h5A);
    tick();
    chk("p5_count", count5, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
